// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered read data, occupancy count and almost-full/empty flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     en_wr,
  input  logic                     en_rd,
`ifdef SYNC_FIFO_ERR_EN
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              wr_acc, rd_acc;

  // Flags come only from registered pointers; the MSB is the wrap bit that
  // separates a full FIFO from an empty one when the addresses match.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_count   = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (data_count >= AF_THR);
  assign almost_empty = (data_count <= AE_THR);
  assign data_out     = data_out_q;

  always_comb begin
    wr_acc     = en_wr && !full;
    rd_acc     = en_rd && !empty;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_acc};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_acc};
    data_out_d = rd_acc ? mem[rd_ptr_q[AW-1:0]] : data_out_q;
  end

  // NOTE: storage has no reset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= data_in;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the same cycle as err_clr wins, so no event is lost.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (en_wr && full)  overflow_d  = 1'b1;
    if (en_rd && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16) against a queue-based model.
// Error-flag scenario is built only when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              en_wr = 1'b0;
  logic              en_rd = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              full, empty, almost_full, almost_empty;
  logic [4:0]        data_count;
`ifdef SYNC_FIFO_ERR_EN
  logic              err_clr = 1'b0;
  logic              overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  logic [8:0]        dut_status;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .en_wr        (en_wr),
    .en_rd        (en_rd),
`ifdef SYNC_FIFO_ERR_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count)
  );

  always #5 clk = ~clk;

  assign dut_status = {full, empty, almost_full, almost_empty, data_count};

  // Expected {full, empty, almost_full, almost_empty, count} from model occupancy.
  function automatic logic [8:0] exp_status();
    int n;
    n = model_q.size();
    return {n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2, 5'(n)};
  endfunction

  // One clock of stimulus; the model applies acceptance rules from pre-edge occupancy.
  task automatic cycle(input logic wr, input logic rd, input logic [DATA_W-1:0] din);
    bit do_wr, do_rd;
    @(negedge clk);
    en_wr   = wr;
    en_rd   = rd;
    data_in = din;
    do_rd   = rd && (model_q.size() > 0);
    do_wr   = wr && (model_q.size() < DEPTH);
    if (do_rd) exp_dout = model_q.pop_front();
    if (do_wr) model_q.push_back(din);
    @(posedge clk);
    #1;
    en_wr = 1'b0;
    en_rd = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_status !== 9'b0_1_0_1_00000) begin
      errors++;
      $display("FAIL reset_status got %b exp %b", dut_status, 9'b0_1_0_1_00000);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout got %h exp 00", data_out);
    end
`ifdef SYNC_FIFO_ERR_EN
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_err got %b exp 00", {overflow, underflow});
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    exp_dout = '0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      checks++;
      if (dut_status !== exp_status()) begin
        errors++;
        $display("FAIL fill[%0d] status got %b exp %b", i, dut_status, exp_status());
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'(i)) begin
        errors++;
        $display("FAIL drain[%0d] dout got %h exp %h", i, data_out, 8'(i));
      end
      checks++;
      if (dut_status !== exp_status()) begin
        errors++;
        $display("FAIL drain[%0d] status got %b exp %b", i, dut_status, exp_status());
      end
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'h5A);
    checks++;
    if (data_count !== 5'd15 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_simul count got %0d/%b exp 15/0", data_count, full);
    end
    checks++;
    if (data_out !== exp_dout) begin
      errors++;
      $display("FAIL full_simul head got %h exp %h", data_out, exp_dout);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== exp_dout) begin
        errors++;
        $display("FAIL full_simul_drain[%0d] got %h exp %h", i, data_out, exp_dout);
      end
    end
    checks++;
    if (dut_status !== 9'b0_1_0_1_00000) begin
      errors++;
      $display("FAIL full_simul_empty got %b exp %b", dut_status, 9'b0_1_0_1_00000);
    end
  endtask

  task automatic test_steady();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom));
      checks++;
      if (data_count !== 5'd5 || data_out !== exp_dout) begin
        errors++;
        $display("FAIL steady[%0d] count %0d dout %h exp 5 %h", i, data_count, data_out, exp_dout);
      end
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== exp_dout || empty !== 1'b1) begin
      errors++;
      $display("FAIL steady_tail dout %h empty %b exp %h 1", data_out, empty, exp_dout);
    end
  endtask

  task automatic test_random();
    int wr_pct;
    for (int i = 0; i < 400; i++) begin
      wr_pct = ((i / 50) % 2 == 0) ? 75 : 25;
      cycle(($urandom_range(99) < wr_pct), ($urandom_range(99) >= wr_pct), 8'($urandom));
      checks++;
      if (dut_status !== exp_status() || data_out !== exp_dout) begin
        errors++;
        $display("FAIL random[%0d] status %b dout %h exp %b %h",
                 i, dut_status, data_out, exp_status(), exp_dout);
      end
    end
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'($urandom));
    checks++;
    if (data_count !== 5'd9) begin
      errors++;
      $display("FAIL reset_mid_pre count got %0d exp 9", data_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_status !== 9'b0_1_0_1_00000 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid status %b dout %h exp %b 00", dut_status, data_out, 9'b0_1_0_1_00000);
    end
    model_q.delete();
    exp_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'hAA || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after dout %h empty %b exp AA 1", data_out, empty);
    end
  endtask

`ifdef SYNC_FIFO_ERR_EN
  task automatic test_err_flags();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b0, 8'hEE);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if ({overflow, underflow} !== 2'b10 || data_count !== 5'd16) begin
      errors++;
      $display("FAIL err_overflow got %b count %0d exp 10 16", {overflow, underflow}, data_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== exp_dout) begin
        errors++;
        $display("FAIL err_drain[%0d] got %h exp %h", i, data_out, exp_dout);
      end
    end
    cycle(1'b0, 1'b1, 8'h00);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if ({overflow, underflow} !== 2'b11 || data_out !== exp_dout) begin
      errors++;
      $display("FAIL err_underflow got %b dout %h exp 11 %h", {overflow, underflow}, data_out, exp_dout);
    end
    // Set condition in the same cycle as err_clr keeps underflow set.
    @(negedge clk);
    err_clr = 1'b1;
    en_rd   = 1'b1;
    @(posedge clk);
    #1;
    en_rd = 1'b0;
    checks++;
    if ({overflow, underflow} !== 2'b01) begin
      errors++;
      $display("FAIL err_priority got %b exp 01", {overflow, underflow});
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL err_clear got %b exp 00", {overflow, underflow});
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_simul();
    test_steady();
    test_random();
    test_reset_mid();
`ifdef SYNC_FIFO_ERR_EN
    test_err_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
